// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
// Holds the default line/address widths, the wait-counter width and the
// arbiter state encoding, plus the round-robin winner selection.
package mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 256;
  localparam int unsigned ARB_WAIT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Winner for an IDLE cycle: a lone requester always wins; on a tie the
  // requester that was not granted last time wins.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last_owner);
    if (req0 && req1) begin
      return ~last_owner;
    end
    return req1 & ~req0;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single cache-line memory port.
//
// State table:
//   ST_IDLE | no transaction; arbitrate pending requests on each edge
//   ST_BUSY | memory port driven with the latched request; wait for ack/timeout
//   ST_DONE | one bubble cycle with the memory port released
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   rN_enable_i/write_i        request valid (held until ack) and direction
//   rN_addr_i/data_i           line address and write line
//   rN_ack_o/data_o            one-cycle completion pulse, read line (held)
//   mem_enable_o/write_o/addr_o/data_o   memory request, registered
//   mem_ack_i/mem_data_i       memory completion and read line
//   owner_o                    current or last grantee (0 = r0, 1 = r1)
//   timeout_o                  sticky flag, set when memory never answered
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_data_i,
  output logic              r0_ack_o,
  output logic [DATA_W-1:0] r0_data_o,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_data_i,
  output logic              r1_ack_o,
  output logic [DATA_W-1:0] r1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              owner_o,
  output logic              timeout_o
);

  // BUSY lasts at most TIMEOUT cycles: the last one is the cycle in which
  // the counter sits at TIMEOUT-1.
  localparam logic [ARB_WAIT_W-1:0] WAIT_LAST = ARB_WAIT_W'(TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    mem_enable_q, mem_enable_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_data_q, mem_data_d;
  logic [ARB_WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    r0_ack_q, r0_ack_d;
  logic                    r1_ack_q, r1_ack_d;
  logic [DATA_W-1:0]       r0_data_q, r0_data_d;
  logic [DATA_W-1:0]       r1_data_q, r1_data_d;
  logic                    timeout_q, timeout_d;

  logic                    grant_sel;
  logic                    finish;
  logic [DATA_W-1:0]       resp_data;

  assign grant_sel = pick_winner(r0_enable_i, r1_enable_i, owner_q);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    wait_cnt_d   = wait_cnt_q;
    r0_ack_d     = 1'b0;
    r1_ack_d     = 1'b0;
    r0_data_d    = r0_data_q;
    r1_data_d    = r1_data_q;
    timeout_d    = timeout_q;
    finish       = 1'b0;
    resp_data    = '0;

    case (state_q)
      ST_IDLE: begin
        if (r0_enable_i || r1_enable_i) begin
          state_d      = ST_BUSY;
          owner_d      = grant_sel;
          mem_enable_d = 1'b1;
          mem_write_d  = grant_sel ? r1_write_i : r0_write_i;
          mem_addr_d   = grant_sel ? r1_addr_i  : r0_addr_i;
          mem_data_d   = grant_sel ? r1_data_i  : r0_data_i;
          wait_cnt_d   = '0;
        end
      end

      ST_BUSY: begin
        // A real ack wins over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          finish    = 1'b1;
          resp_data = mem_data_i;
        end else if (wait_cnt_q == WAIT_LAST) begin
          finish    = 1'b1;
          resp_data = '0;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (finish) begin
          state_d      = ST_DONE;
          mem_enable_d = 1'b0;
          if (owner_q) begin
            r1_ack_d = 1'b1;
          end else begin
            r0_ack_d = 1'b1;
          end
          // Only reads deliver a line; a write (even a timed-out one)
          // leaves the requester's last read line in place.
          if (!mem_write_q) begin
            if (owner_q) begin
              r1_data_d = resp_data;
            end else begin
              r0_data_d = resp_data;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b1;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      wait_cnt_q   <= '0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_data_q    <= '0;
      r1_data_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      wait_cnt_q   <= wait_cnt_d;
      r0_ack_q     <= r0_ack_d;
      r1_ack_q     <= r1_ack_d;
      r0_data_q    <= r0_data_d;
      r1_data_q    <= r1_data_d;
      timeout_q    <= timeout_d;
    end
  end

  assign r0_ack_o     = r0_ack_q;
  assign r1_ack_o     = r1_ack_q;
  assign r0_data_o    = r0_data_q;
  assign r1_data_o    = r1_data_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign owner_o      = owner_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 15;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          to;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          r0_enable_i, r0_write_i, r1_enable_i, r1_write_i;
  logic [AW-1:0] r0_addr_i, r1_addr_i;
  logic [DW-1:0] r0_data_i, r1_data_i;
  logic          r0_ack_o, r1_ack_o;
  logic [DW-1:0] r0_data_o, r1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;
  logic          owner_o, timeout_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_enable_i(r0_enable_i), .r0_write_i(r0_write_i), .r0_addr_i(r0_addr_i),
    .r0_data_i(r0_data_i), .r0_ack_o(r0_ack_o), .r0_data_o(r0_data_o),
    .r1_enable_i(r1_enable_i), .r1_write_i(r1_write_i), .r1_addr_i(r1_addr_i),
    .r1_data_i(r1_data_i), .r1_ack_o(r1_ack_o), .r1_data_o(r1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .owner_o(owner_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Scoreboard and reference model state.
  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] shadow[logic [AW-1:0]];
  logic [DW-1:0] dmem[logic [AW-1:0]];
  logic [DW-1:0] mon_rd[2];
  bit            model_owner = 1'b1;
  bit            model_to = 1'b0;
  int            ack_cnt[2];
  int            last_ack_cyc[2];
  int            last_grant_cyc[2];
  int            last_busy = 0;
  bit            grants[$];

  // Memory responder controls.
  bit silent = 1'b0;
  bit noise = 1'b0;
  int lat_force = -1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_line(input logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic logic [DW-1:0] ref_line(input logic [AW-1:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_line(a);
  endfunction

  function automatic logic [DW-1:0] mem_line(input logic [AW-1:0] a);
    if (dmem.exists(a)) return dmem[a];
    return init_line(a);
  endfunction

  function automatic logic get_ack(input int n);
    return (n == 0) ? r0_ack_o : r1_ack_o;
  endfunction

  task automatic set_req(input int n, input logic e, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      r0_enable_i = e; r0_write_i = w; r0_addr_i = a; r0_data_i = d;
    end else begin
      r1_enable_i = e; r1_write_i = w; r1_addr_i = a; r1_data_i = d;
    end
  endtask

  // Issue one request, record what the requester should see, hold enable
  // until the ack arrives (bounded), then release.
  task automatic issue(input int n, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic to);
    exp_t e;
    int   k;
    e.wr = wr; e.addr = a; e.wdata = d; e.to = to;
    e.rdata = (wr || to) ? '0 : ref_line(a);
    if (wr) shadow[a] = d;
    if (n == 0) q0.push_back(e); else q1.push_back(e);
    set_req(n, 1'b1, wr, a, d);
    k = 0;
    do begin
      @(posedge clk_i); #1;
      k++;
    end while (!get_ack(n) && k < 200);
    checks++;
    if (!get_ack(n)) begin
      errors++;
      $display("FAIL ack_wait r%0d actual=no_ack required=ack_within_200", n);
    end
    set_req(n, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_stream(input int n, input int cnt);
    int            g;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < cnt; i++) begin
      g  = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk_i); #1; end
      wr = 1'($urandom_range(0, 1));
      a  = ((n == 0) ? 32'h0 : 32'h200) + 32'($urandom_range(0, 15) * 32);
      d  = {8{$urandom()}};
      issue(n, wr, a, d, 1'b0);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Memory model: random latency per transaction, optional silence, and
  // optional stray acks while the port is idle.
  initial begin : responder
    int lat;
    bit act;
    act = 1'b0;
    lat = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      if (mem_enable_o && !silent) begin
        if (!act) begin
          act = 1'b1;
          lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 12));
        end
        if (lat == 0) begin
          mem_ack_i = 1'b1;
          if (mem_write_o) dmem[mem_addr_o] = mem_data_o;
          else mem_data_i = mem_line(mem_addr_o);
        end else begin
          lat--;
        end
      end else if (!mem_enable_o) begin
        act = 1'b0;
        if (noise && $urandom_range(0, 7) == 0) begin
          mem_ack_i = 1'b1;
          mem_data_i = {8{$urandom()}};
        end
      end
    end
  end

  // Monitor: checks grants against the round-robin rule, memory-port
  // stability during BUSY, and pops the scoreboard on every ack.
  initial begin : monitor
    bit            pen0, pen1, pmen, pack0, pack1, w, a;
    int            busy_cnt, qs;
    logic [AW-1:0] baddr;
    logic          bwr;
    logic [DW-1:0] bdata, rd, rd_oth;
    exp_t          e;
    pen0 = 0; pen1 = 0; pmen = 0; pack0 = 0; pack1 = 0; busy_cnt = 0;
    baddr = '0; bwr = 1'b0; bdata = '0;
    mon_rd[0] = '0; mon_rd[1] = '0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        pen0 = 0; pen1 = 0; pmen = 0; pack0 = 0; pack1 = 0; busy_cnt = 0;
        model_owner = 1'b1; model_to = 1'b0;
        mon_rd[0] = '0; mon_rd[1] = '0;
        q0.delete(); q1.delete();
        continue;
      end
      if (mem_enable_o && !pmen) begin
        w = (pen0 && pen1) ? !model_owner : !pen0;
        chk("grant_has_request", DW'(pen0 || pen1), DW'(1));
        chk("grant_owner", DW'(owner_o), DW'(w));
        model_owner = w;
        grants.push_back(w);
        last_grant_cyc[w] = cyc;
        qs = (w == 0) ? q0.size() : q1.size();
        chk("grant_pending_txn", DW'(qs > 0), DW'(1));
        if (qs > 0) begin
          e = (w == 0) ? q0[0] : q1[0];
          chk("grant_mem_write", DW'(mem_write_o), DW'(e.wr));
          chk("grant_mem_addr", DW'(mem_addr_o), DW'(e.addr));
          chk("grant_mem_data", mem_data_o, e.wdata);
        end
        bwr = mem_write_o; baddr = mem_addr_o; bdata = mem_data_o;
        busy_cnt = 1;
      end else if (mem_enable_o) begin
        chk("busy_hold", {mem_write_o, mem_addr_o, mem_data_o[DW-34:0]},
            {bwr, baddr, bdata[DW-34:0]});
        busy_cnt++;
      end
      for (int n = 0; n < 2; n++) begin
        a      = (n == 0) ? r0_ack_o : r1_ack_o;
        rd     = (n == 0) ? r0_data_o : r1_data_o;
        rd_oth = (n == 0) ? r1_data_o : r0_data_o;
        if (a) begin
          ack_cnt[n]++;
          last_ack_cyc[n] = cyc;
          last_busy = busy_cnt;
          chk("ack_single_cycle", DW'((n == 0) ? pack0 : pack1), DW'(0));
          chk("ack_is_owner", DW'(n), DW'(model_owner));
          chk("ack_other_data_kept", rd_oth, mon_rd[1-n]);
          qs = (n == 0) ? q0.size() : q1.size();
          chk("ack_expected", DW'(qs > 0), DW'(1));
          if (qs > 0) begin
            e = (n == 0) ? q0.pop_front() : q1.pop_front();
            if (e.to) model_to = 1'b1;
            if (!e.wr) mon_rd[n] = e.rdata;
            chk(e.wr ? "ack_data_after_write" : "ack_read_data", rd, mon_rd[n]);
            chk("timeout_flag", DW'(timeout_o), DW'(model_to));
          end
        end
      end
      pen0 = r0_enable_i; pen1 = r1_enable_i; pmen = mem_enable_o;
      pack0 = r0_ack_o; pack1 = r1_ack_o;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "simulation time budget exceeded");
  end

  initial begin : main
    logic [DW-1:0]  line0, pat;
    logic [127:0]   half;
    logic [3:0]     nib;
    int             k;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_mem_enable", DW'(mem_enable_o), DW'(0));
    chk("rst_mem_write", DW'(mem_write_o), DW'(0));
    chk("rst_mem_addr", DW'(mem_addr_o), DW'(0));
    chk("rst_mem_data", mem_data_o, '0);
    chk("rst_acks", DW'({r0_ack_o, r1_ack_o}), DW'(0));
    chk("rst_r0_data", r0_data_o, '0);
    chk("rst_r1_data", r1_data_o, '0);
    chk("rst_owner", DW'(owner_o), DW'(1));
    chk("rst_timeout", DW'(timeout_o), DW'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // r0 read of line 0 with a 10-cycle memory.
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      line0[DW-1-16*i -: 16] = {4{nib}};
    end
    dmem[32'h0] = line0;
    shadow[32'h0] = line0;
    lat_force = 10;
    issue(0, 1'b0, 32'h0, '0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("read0_data", r0_data_o, line0);
    chk("read0_r0_ack_count", DW'(ack_cnt[0]), DW'(1));
    chk("read0_r1_ack_count", DW'(ack_cnt[1]), DW'(0));
    lat_force = -1;

    // Tie straight after reset: r0 first, r1 in the next IDLE.
    rst_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1;
    grants.delete();
    fork
      issue(0, 1'b0, 32'h20, {8{32'h1111_0000}}, 1'b0);
      issue(1, 1'b0, 32'h220, {8{32'h2222_0000}}, 1'b0);
    join
    repeat (2) @(posedge clk_i);
    #1;
    chk("tie_grant_count", DW'(grants.size()), DW'(2));
    if (grants.size() == 2) begin
      chk("tie_first_owner", DW'(grants[0]), DW'(0));
      chk("tie_second_owner", DW'(grants[1]), DW'(1));
    end
    chk("tie_regrant_gap", DW'(last_grant_cyc[1] - last_ack_cyc[0]), DW'(2));

    // r1 line write to 0x200.
    half = 128'h0123456789ABCDEFFEDCBA9876543210;
    pat = {half, half};
    issue(1, 1'b1, 32'h200, pat, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("write_mem_line16", mem_line(32'h200), pat);
    chk("write_r1_data_kept", r1_data_o, init_line(32'h220));

    // Concurrent random traffic with stray memory acks while idle.
    noise = 1'b1;
    fork
      rand_stream(0, 40);
      rand_stream(1, 40);
    join
    noise = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rand_all_drained", DW'(q0.size() + q1.size()), DW'(0));

    // Silent memory: timeout after TO busy cycles, flag stays set.
    silent = 1'b1;
    issue(0, 1'b0, 32'h60, '0, 1'b1);
    silent = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("timeout_busy_cycles", DW'(last_busy), DW'(TO));
    chk("timeout_sticky", DW'(timeout_o), DW'(1));
    chk("timeout_port_idle", DW'(mem_enable_o), DW'(0));
    issue(1, 1'b0, 32'h260, '0, 1'b0);

    // Reset in the fourth busy cycle.
    lat_force = 12;
    q0.push_back('{wr: 1'b0, addr: 32'h40, wdata: '0, rdata: '0, to: 1'b0});
    set_req(0, 1'b1, 1'b0, 32'h40, '0);
    k = 0;
    do begin
      @(posedge clk_i); #1;
      k++;
    end while (!mem_enable_o && k < 20);
    chk("rstbusy_granted", DW'(mem_enable_o), DW'(1));
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rstbusy_mem_enable", DW'(mem_enable_o), DW'(0));
    chk("rstbusy_no_ack", DW'({r0_ack_o, r1_ack_o}), DW'(0));
    chk("rstbusy_timeout_clr", DW'(timeout_o), DW'(0));
    chk("rstbusy_owner", DW'(owner_o), DW'(1));
    set_req(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rstbusy_r0_no_late_ack", DW'(r0_ack_o), DW'(0));
    rst_i = 1'b1;
    lat_force = -1;
    issue(1, 1'b0, 32'h240, '0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rstbusy_r1_data", r1_data_o, ref_line(32'h240));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-002 Parameter DATA_W, default 256, SHALL set the line width (one cache line).
REQ-003 Parameter TIMEOUT, default 1023, SHALL set the maximum cycles to wait for mem_ack_i.
REQ-004 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 rN_enable_i  in  1 (N=0,1)  SHALL be the request valid, held high until rN_ack_o.
REQ-007 rN_write_i  in  1  SHALL select write (1) or read (0).
REQ-008 rN_addr_i  in  ADDR_W  SHALL be the line-aligned byte address.
REQ-009 rN_data_i  in  DATA_W  SHALL be the write data.
REQ-010 rN_ack_o  out  1  SHALL be the one-cycle completion pulse.
REQ-011 rN_data_o  out  DATA_W  SHALL be the read data, valid when rN_ack_o=1.
REQ-012 mem_enable_o / mem_write_o / mem_addr_o / mem_data_o  out  1/1/ADDR_W/DATA_W  SHALL drive the Data_Memory port.
REQ-013 mem_ack_i / mem_data_i  in  1/DATA_W  SHALL be the memory completion and read data.
REQ-014 owner_o  out  1  SHALL give the current or last grantee (0 = r0, 1 = r1).
REQ-015 timeout_o  out  1  SHALL be a sticky error flag, cleared only by reset.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 IDLE SHALL go to BUSY when either rN_enable_i=1.
- Only one request: grant it.
- Both requests: grant the one not equal to owner_o (round-robin).
REQ-018 On grant, the block SHALL register the winner's write, addr and data, and SHALL NOT re-sample them during BUSY.
REQ-019 In BUSY, mem_enable_o SHALL be 1, and mem_write_o/mem_addr_o/mem_data_o SHALL equal the registered values.
REQ-020 In BUSY, mem_ack_i=1 SHALL cause the following in the same edge:
- capture mem_data_i into the winner's rN_data_o register;
- pulse the winner's rN_ack_o for exactly one cycle;
- move to DONE.
REQ-021 DONE SHALL hold mem_enable_o=0 for one cycle, then move to IDLE; minimum request-to-request spacing is therefore 3 cycles plus memory latency.
REQ-022 The non-owner's rN_ack_o SHALL remain 0 at all times.
REQ-023 rN_data_o SHALL keep its value until that requester's next read completion; writes SHALL NOT update it.
REQ-024 A 10-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- Count reaching TIMEOUT: set timeout_o, pulse the winner's ack with data zero, move to DONE.
REQ-025 mem_ack_i outside BUSY SHALL be ignored.
REQ-026 A requester dropping rN_enable_i mid-BUSY SHALL NOT abort the transaction; it still completes and acks.
REQ-027 Grant decision, ack and data outputs SHALL be registered, with no combinational path from rN_enable_i to mem_*.

Reset
REQ-028 rst_i=0 SHALL asynchronously force:
- state IDLE, owner_o=1 (so r0 wins the first tie);
- all mem_* outputs, rN_ack_o, rN_data_o, timeout_o and the wait counter to 0.
REQ-029 Reset mid-BUSY SHALL abandon the transaction without acking; the first request after release SHALL be arbitrated afresh.

Structure
REQ-030 State encoding and the default DATA_W/ADDR_W constants SHALL live in the shared CPU package.
REQ-031 The block SHALL be a single module with no sub-module; it is instantiated in CPU between dcache and the memory port.

Verification
REQ-032 r0 read 0x0000, memory acks after 10 cycles with line 0x0000_1111…FFFF -> r0_ack_o pulses once and r0_data_o equals that line; r1_ack_o stays 0.
REQ-033 r0 and r1 assert in the same cycle after reset -> r0 served first; r1 granted in the first IDLE after DONE; owner_o reads 0 then 1.
REQ-034 r1 write addr 0x0200 with data 0x0123…3210 -> mem_write_o=1 and mem_addr_o=0x0200 throughout BUSY; Data_Memory line 16 updated; r1_data_o unchanged.
REQ-035 Memory never acks with TIMEOUT=15 -> after 15 BUSY cycles timeout_o=1 (sticky), ack pulses with data 0, FSM returns to IDLE.
REQ-036 rst_i driven low at BUSY cycle 4 -> mem_enable_o=0 immediately, no ack; after release a new r1 request completes normally.
